ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Downstream consumer of the main decoder's control outputs in the 5-stage MIPS pipeline.
- Registers decode-stage control bits and register specifiers through the ID/EX, EX/MEM and MEM/WB boundaries.
- Computes the destination register in EX.
- Detects load-use hazards (stall plus bubble), applies branch/jump flushes and produces EX-stage forwarding selects for the ALU operand muxes.

Parameters:
- REGW, 5, register-specifier width.
- ALUCW, 3, ALU control field width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- regwrite_d  in  1  decode: writes register file.
- memtoreg_d  in  1  decode: load (result from memory).
- memwrite_d  in  1  decode: store.
- alusrc_d  in  1  decode: ALU B operand is the immediate.
- regdst_d  in  1  decode: destination is rd (else rt).
- alucontrol_d  in  ALUCW  decode: ALU operation.
- rs_d, rt_d, rd_d  in  REGW each  decode register specifiers.
- flush_e  in  1  branch taken / jump: squash the instruction entering EX.
- regwrite_e, memtoreg_e, memwrite_e, alusrc_e  out  1 each  EX-stage controls.
- alucontrol_e  out  ALUCW  EX ALU control.
- rs_e, rt_e  out  REGW each  EX source specifiers.
- writereg_e  out  REGW  EX destination (combinational from EX registers).
- regwrite_m, memtoreg_m, memwrite_m  out  1 each  MEM controls.
- writereg_m  out  REGW  MEM destination.
- regwrite_w, memtoreg_w  out  1 each  WB controls.
- writereg_w  out  REGW  WB destination.
- stall_f, stall_d  out  1 each  hold PC and IF/ID register.
- forward_ae, forward_be  out  2 each  operand select: 00 register file, 10 MEM result, 01 WB result.

Behaviour:
- Reset (reset=0, async): every registered field in all three stages clears to 0, so no regwrite/memwrite occurs in any stage. Combinational outputs follow the cleared state: writereg_e=0, stall_f=stall_d=0, forward_*=00.
- Reset deasserts synchronously to clk; the first capture is on the first rising edge with reset=1.
- Normal advance (no stall/flush): each rising edge moves D→E, E→M, M→W. Latency per stage boundary is 1 cycle; WB sees decode values 3 edges later.
- writereg_e = regdst_e ? rd_e : rt_e. Only the resolved writereg is carried into M and W (regdst/rd are not).
- Load-use hazard, combinational: lwstall = memtoreg_e & (rt_e != 0) & ((rt_e == rs_d) | (rt_e == rt_d)).
- stall_f = stall_d = lwstall.
- Bubble: if lwstall | flush_e, the E register loads all-zero controls and zero specifiers on the next edge; M and W still advance.
- flush_e and lwstall in the same cycle produce a single bubble, identical to either alone; the stall outputs still assert from lwstall.
- The D-stage inputs are held externally while stall_d=1; this block keeps no copy of them.
- Forwarding for A (same rule for B with rt_e):
  - 10 if rs_e != 0 & regwrite_m & (writereg_m == rs_e);
  - else 01 if rs_e != 0 & regwrite_w & (writereg_w == rs_e);
  - else 00.
  - MEM has priority over WB. Register 0 is never forwarded.
- Bubbles carry regwrite=0 and therefore never trigger forwarding or stalls.
- Reset asserted mid-operation clears all stages immediately; in-flight instructions are discarded and produce no writes.
- No X may propagate: with decode inputs at X, a bubble still loads known zeros.

Test Plan:
- Reset then 3 clocks with decode regwrite_d=1, regdst_d=1, rd_d=8 → regwrite_w=1, writereg_w=8 on the 3rd edge; before that, regwrite_w=0.
- lw with rt=9 in EX (memtoreg_e=1), decode rs_d=9 → stall_f=stall_d=1 for exactly 1 cycle; next cycle regwrite_e=0 and memwrite_e=0 (bubble), and the load advances to M.
- Load in EX with rt_e=0, decode rs_d=0 → no stall.
- add to $10 in M, an older add to $10 in W, EX rs_e=10 → forward_ae=10. Remove the M writer → forward_ae=01. Set rs_e=0 with writers targeting $0 → forward_ae=00.
- flush_e=1 with a store (memwrite_d=1) in decode → memwrite_e=0 next cycle and no memwrite_m afterwards. Assert flush_e and lwstall together → exactly one bubble.
- Drive reset low asynchronously mid-cycle with regwrite_m=1 and memwrite_e=1 → all outputs read 0 before the next clock edge; after release, the pipeline refills from decode normally.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control-side pipeline registers for the 5-stage MIPS core: ID/EX, EX/MEM, MEM/WB
// control fields, EX destination selection, load-use stall and EX forwarding selects.
module ctrl_pipe #(
   parameter int REGW  = 5,
   parameter int ALUCW = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             regwrite_d,
   input  logic             memtoreg_d,
   input  logic             memwrite_d,
   input  logic             alusrc_d,
   input  logic             regdst_d,
   input  logic [ALUCW-1:0] alucontrol_d,
   input  logic [REGW-1:0]  rs_d,
   input  logic [REGW-1:0]  rt_d,
   input  logic [REGW-1:0]  rd_d,
   input  logic             flush_e,
   output logic             regwrite_e,
   output logic             memtoreg_e,
   output logic             memwrite_e,
   output logic             alusrc_e,
   output logic [ALUCW-1:0] alucontrol_e,
   output logic [REGW-1:0]  rs_e,
   output logic [REGW-1:0]  rt_e,
   output logic [REGW-1:0]  writereg_e,
   output logic             regwrite_m,
   output logic             memtoreg_m,
   output logic             memwrite_m,
   output logic [REGW-1:0]  writereg_m,
   output logic             regwrite_w,
   output logic             memtoreg_w,
   output logic [REGW-1:0]  writereg_w,
   output logic             stall_f,
   output logic             stall_d,
   output logic [1:0]       forward_ae,
   output logic [1:0]       forward_be
);

   logic            regdst_e;
   logic [REGW-1:0] rd_e;
   logic            lwstall;
   logic            bubble;

   assign writereg_e = regdst_e ? rd_e : rt_e;

   assign lwstall = memtoreg_e & (rt_e != '0) & ((rt_e == rs_d) | (rt_e == rt_d));
   assign stall_f = lwstall;
   assign stall_d = lwstall;
   assign bubble  = lwstall | flush_e;

   // Bubble loads literal zeros rather than gating the decode inputs, so X on D cannot leak in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regwrite_e   <= 1'b0;
         memtoreg_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         alusrc_e     <= 1'b0;
         regdst_e     <= 1'b0;
         alucontrol_e <= '0;
         rs_e         <= '0;
         rt_e         <= '0;
         rd_e         <= '0;
      end else if (bubble) begin
         regwrite_e   <= 1'b0;
         memtoreg_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         alusrc_e     <= 1'b0;
         regdst_e     <= 1'b0;
         alucontrol_e <= '0;
         rs_e         <= '0;
         rt_e         <= '0;
         rd_e         <= '0;
      end else begin
         regwrite_e   <= regwrite_d;
         memtoreg_e   <= memtoreg_d;
         memwrite_e   <= memwrite_d;
         alusrc_e     <= alusrc_d;
         regdst_e     <= regdst_d;
         alucontrol_e <= alucontrol_d;
         rs_e         <= rs_d;
         rt_e         <= rt_d;
         rd_e         <= rd_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regwrite_m <= 1'b0;
         memtoreg_m <= 1'b0;
         memwrite_m <= 1'b0;
         writereg_m <= '0;
         regwrite_w <= 1'b0;
         memtoreg_w <= 1'b0;
         writereg_w <= '0;
      end else begin
         regwrite_m <= regwrite_e;
         memtoreg_m <= memtoreg_e;
         memwrite_m <= memwrite_e;
         writereg_m <= writereg_e;
         regwrite_w <= regwrite_m;
         memtoreg_w <= memtoreg_m;
         writereg_w <= writereg_m;
      end
   end

   // MEM result is younger than WB, so it wins; $0 is hardwired and never forwarded.
   always_comb begin
      forward_ae = 2'b00;
      forward_be = 2'b00;
      if ((rs_e != '0) && regwrite_m && (writereg_m == rs_e))
         forward_ae = 2'b10;
      else if ((rs_e != '0) && regwrite_w && (writereg_w == rs_e))
         forward_ae = 2'b01;
      if ((rt_e != '0) && regwrite_m && (writereg_m == rt_e))
         forward_be = 2'b10;
      else if ((rt_e != '0) && regwrite_w && (writereg_w == rt_e))
         forward_be = 2'b01;
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: whole-instruction pipeline model compared every
// cycle, directed hazard/forward/flush/reset scenarios, then randomized traffic.
module tb_ctrl_pipe;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regdst;
      logic [2:0] aluc;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } instr_t;

   logic       clk;
   logic       reset;
   logic       regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
   logic [2:0] alucontrol_d;
   logic [4:0] rs_d, rt_d, rd_d;
   logic       flush_e;
   logic       regwrite_e, memtoreg_e, memwrite_e, alusrc_e;
   logic [2:0] alucontrol_e;
   logic [4:0] rs_e, rt_e, writereg_e;
   logic       regwrite_m, memtoreg_m, memwrite_m;
   logic [4:0] writereg_m;
   logic       regwrite_w, memtoreg_w;
   logic [4:0] writereg_w;
   logic       stall_f, stall_d;
   logic [1:0] forward_ae, forward_be;

   int checks   = 0;
   int failures = 0;
   bit check_en = 0;

   instr_t mdl_e, mdl_m, mdl_w;
   bit     mdl_bub;

   ctrl_pipe dut (
      .clk(clk), .reset(reset),
      .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
      .alusrc_d(alusrc_d), .regdst_d(regdst_d), .alucontrol_d(alucontrol_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e(flush_e),
      .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
      .alusrc_e(alusrc_e), .alucontrol_e(alucontrol_e), .rs_e(rs_e), .rt_e(rt_e),
      .writereg_e(writereg_e), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
      .memwrite_m(memwrite_m), .writereg_m(writereg_m), .regwrite_w(regwrite_w),
      .memtoreg_w(memtoreg_w), .writereg_w(writereg_w), .stall_f(stall_f),
      .stall_d(stall_d), .forward_ae(forward_ae), .forward_be(forward_be)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] dest(input instr_t i);
      return i.regdst ? i.rd : i.rt;
   endfunction

   function automatic instr_t d_instr();
      instr_t i;
      i = '{regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d,
            alucontrol_d, rs_d, rt_d, rd_d};
      return i;
   endfunction

   function automatic bit model_stall();
      return mdl_e.memtoreg && (mdl_e.rt != 0) && ((mdl_e.rt == rs_d) || (mdl_e.rt == rt_d));
   endfunction

   function automatic logic [1:0] model_fwd(input logic [4:0] src);
      if (src != 0 && mdl_m.regwrite && dest(mdl_m) == src) return 2'b10;
      if (src != 0 && mdl_w.regwrite && dest(mdl_w) == src) return 2'b01;
      return 2'b00;
   endfunction

   // Reference: each stage holds a whole instruction; a bubble is the all-zero instruction.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mdl_e = '0;
         mdl_m = '0;
         mdl_w = '0;
      end else begin
         mdl_bub = model_stall() || (flush_e === 1'b1);
         mdl_w = mdl_m;
         mdl_m = mdl_e;
         mdl_e = mdl_bub ? instr_t'('0) : d_instr();
      end
   end

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check_output("regwrite_e", 16'(regwrite_e), 16'(mdl_e.regwrite));
      check_output("memtoreg_e", 16'(memtoreg_e), 16'(mdl_e.memtoreg));
      check_output("memwrite_e", 16'(memwrite_e), 16'(mdl_e.memwrite));
      check_output("alusrc_e", 16'(alusrc_e), 16'(mdl_e.alusrc));
      check_output("alucontrol_e", 16'(alucontrol_e), 16'(mdl_e.aluc));
      check_output("rs_e", 16'(rs_e), 16'(mdl_e.rs));
      check_output("rt_e", 16'(rt_e), 16'(mdl_e.rt));
      check_output("writereg_e", 16'(writereg_e), 16'(dest(mdl_e)));
      check_output("regwrite_m", 16'(regwrite_m), 16'(mdl_m.regwrite));
      check_output("memtoreg_m", 16'(memtoreg_m), 16'(mdl_m.memtoreg));
      check_output("memwrite_m", 16'(memwrite_m), 16'(mdl_m.memwrite));
      check_output("writereg_m", 16'(writereg_m), 16'(dest(mdl_m)));
      check_output("regwrite_w", 16'(regwrite_w), 16'(mdl_w.regwrite));
      check_output("memtoreg_w", 16'(memtoreg_w), 16'(mdl_w.memtoreg));
      check_output("writereg_w", 16'(writereg_w), 16'(dest(mdl_w)));
      check_output("stall_f", 16'(stall_f), 16'(model_stall()));
      check_output("stall_d", 16'(stall_d), 16'(model_stall()));
      check_output("forward_ae", 16'(forward_ae), 16'(model_fwd(mdl_e.rs)));
      check_output("forward_be", 16'(forward_be), 16'(model_fwd(mdl_e.rt)));
   endtask

   always @(negedge clk) if (check_en) check_all();

   task automatic apply_stimulus(input instr_t i, input logic fl);
      regwrite_d   = i.regwrite;
      memtoreg_d   = i.memtoreg;
      memwrite_d   = i.memwrite;
      alusrc_d     = i.alusrc;
      regdst_d     = i.regdst;
      alucontrol_d = i.aluc;
      rs_d         = i.rs;
      rt_d         = i.rt;
      rd_d         = i.rd;
      flush_e      = fl;
      #1;
   endtask

   // Leaves time at posedge+6: after the negedge compare, well before the next edge.
   task automatic tick();
      @(posedge clk);
      #6;
   endtask

   function automatic instr_t mk(input logic rw, input logic mr, input logic mw,
                                 input logic rdst, input logic [4:0] s, input logic [4:0] t,
                                 input logic [4:0] d);
      instr_t i;
      i = '{rw, mr, mw, 1'b0, rdst, 3'd2, s, t, d};
      return i;
   endfunction

   instr_t nop_i, add8_i, lw9_i, use9_i, lw0_i, use0_i, add10_i, use10_i, st_i;

   initial begin
      nop_i   = '0;
      add8_i  = mk(1, 0, 0, 1, 5'd1, 5'd2, 5'd8);
      lw9_i   = mk(1, 1, 0, 0, 5'd4, 5'd9, 5'd0);
      use9_i  = mk(1, 0, 0, 1, 5'd9, 5'd3, 5'd11);
      lw0_i   = mk(1, 1, 0, 0, 5'd4, 5'd0, 5'd0);
      use0_i  = mk(1, 0, 0, 1, 5'd0, 5'd5, 5'd12);
      add10_i = mk(1, 0, 0, 1, 5'd1, 5'd2, 5'd10);
      use10_i = mk(0, 0, 0, 1, 5'd10, 5'd6, 5'd13);
      st_i    = mk(0, 0, 1, 0, 5'd7, 5'd6, 5'd0);

      reset = 1'b0;
      apply_stimulus(nop_i, 1'b0);
      mdl_e = '0; mdl_m = '0; mdl_w = '0;
      check_en = 1;
      tick();
      check_output("reset_regwrite_w", 16'(regwrite_w), 16'd0);
      check_output("reset_memwrite_e", 16'(memwrite_e), 16'd0);
      check_output("reset_forward_ae", 16'(forward_ae), 16'd0);
      reset = 1'b1;

      // Write-back latency: three edges from decode.
      apply_stimulus(add8_i, 1'b0);
      tick();
      check_output("lat_regwrite_e", 16'(regwrite_e), 16'd1);
      check_output("lat_w_edge1", 16'(regwrite_w), 16'd0);
      tick();
      check_output("lat_w_edge2", 16'(regwrite_w), 16'd0);
      tick();
      check_output("lat_w_edge3", 16'(regwrite_w), 16'd1);
      check_output("lat_writereg_w", 16'(writereg_w), 16'd8);

      // Load-use stall for exactly one cycle, then bubble in E.
      apply_stimulus(lw9_i, 1'b0);
      tick();
      apply_stimulus(use9_i, 1'b0);
      check_output("lu_stall_f", 16'(stall_f), 16'd1);
      check_output("lu_stall_d", 16'(stall_d), 16'd1);
      tick();
      check_output("lu_bubble_regwrite_e", 16'(regwrite_e), 16'd0);
      check_output("lu_bubble_memwrite_e", 16'(memwrite_e), 16'd0);
      check_output("lu_load_in_m", 16'(memtoreg_m), 16'd1);
      check_output("lu_writereg_m", 16'(writereg_m), 16'd9);
      check_output("lu_stall_released", 16'(stall_f), 16'd0);
      tick();
      check_output("lu_use_in_e", 16'(rs_e), 16'd9);

      // Load targeting $0 never stalls.
      apply_stimulus(lw0_i, 1'b0);
      tick();
      apply_stimulus(use0_i, 1'b0);
      check_output("lw0_no_stall", 16'(stall_f), 16'd0);

      // Forwarding priority: M over W, then W alone, then $0 never.
      apply_stimulus(add10_i, 1'b0); tick();
      apply_stimulus(add10_i, 1'b0); tick();
      apply_stimulus(use10_i, 1'b0); tick();
      check_output("fwd_mem", 16'(forward_ae), 16'b10);
      apply_stimulus(add10_i, 1'b0); tick();
      apply_stimulus(nop_i, 1'b0); tick();
      apply_stimulus(use10_i, 1'b0); tick();
      check_output("fwd_wb", 16'(forward_ae), 16'b01);
      apply_stimulus(mk(1, 0, 0, 1, 5'd1, 5'd2, 5'd0), 1'b0); tick();
      tick();
      apply_stimulus(mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0), 1'b0); tick();
      check_output("fwd_zero_a", 16'(forward_ae), 16'b00);
      check_output("fwd_zero_b", 16'(forward_be), 16'b00);

      // Flush squashes a store.
      apply_stimulus(st_i, 1'b1); tick();
      check_output("flush_memwrite_e", 16'(memwrite_e), 16'd0);
      apply_stimulus(nop_i, 1'b0); tick();
      check_output("flush_memwrite_m", 16'(memwrite_m), 16'd0);

      // Flush together with load-use yields a single bubble.
      apply_stimulus(lw9_i, 1'b0); tick();
      apply_stimulus(use9_i, 1'b1);
      check_output("both_stall", 16'(stall_f), 16'd1);
      tick();
      check_output("both_bubble", 16'(regwrite_e), 16'd0);
      apply_stimulus(use9_i, 1'b0);
      check_output("both_no_restall", 16'(stall_f), 16'd0);
      tick();
      check_output("both_refill_rs_e", 16'(rs_e), 16'd9);
      check_output("both_bubble_in_m", 16'(memtoreg_m), 16'd0);

      // X on decode inputs during a flush must still load zeros.
      apply_stimulus(nop_i, 1'b1); tick();
      apply_stimulus(instr_t'('x), 1'b1); tick();
      check_output("x_regwrite_e", 16'(regwrite_e), 16'd0);
      check_output("x_rs_e", 16'(rs_e), 16'd0);
      check_output("x_alucontrol_e", 16'(alucontrol_e), 16'd0);
      apply_stimulus(nop_i, 1'b0);

      // Asynchronous reset mid-cycle.
      apply_stimulus(mk(1, 0, 0, 1, 5'd1, 5'd2, 5'd7), 1'b0); tick();
      apply_stimulus(st_i, 1'b0); tick();
      check_output("pre_rst_regwrite_m", 16'(regwrite_m), 16'd1);
      check_output("pre_rst_memwrite_e", 16'(memwrite_e), 16'd1);
      #1 reset = 1'b0;
      #1;
      check_output("arst_regwrite_m", 16'(regwrite_m), 16'd0);
      check_output("arst_memwrite_e", 16'(memwrite_e), 16'd0);
      check_output("arst_writereg_m", 16'(writereg_m), 16'd0);
      check_output("arst_regwrite_w", 16'(regwrite_w), 16'd0);
      tick();
      reset = 1'b1;
      apply_stimulus(mk(1, 0, 0, 1, 5'd1, 5'd2, 5'd5), 1'b0);
      tick(); tick();
      check_output("refill_w_edge2", 16'(regwrite_w), 16'd0);
      tick();
      check_output("refill_regwrite_w", 16'(regwrite_w), 16'd1);
      check_output("refill_writereg_w", 16'(writereg_w), 16'd5);

      // Randomized traffic on a small register set to provoke hazards; D is held while stalled.
      for (int n = 0; n < 500; n++) begin
         if (!model_stall()) begin
            instr_t r;
            r.regwrite = 1'($urandom_range(0, 1));
            r.memtoreg = 1'($urandom_range(0, 2) == 0);
            r.memwrite = 1'($urandom_range(0, 3) == 0);
            r.alusrc   = 1'($urandom_range(0, 1));
            r.regdst   = 1'($urandom_range(0, 1));
            r.aluc     = 3'($urandom_range(0, 7));
            r.rs       = 5'($urandom_range(0, 3));
            r.rt       = 5'($urandom_range(0, 3));
            r.rd       = 5'($urandom_range(0, 3));
            apply_stimulus(r, 1'($urandom_range(0, 7) == 0));
         end else begin
            flush_e = 1'($urandom_range(0, 7) == 0);
         end
         tick();
      end

      check_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
